// File: rtl/angle_table_pkg.sv
// angle_table_pkg: shared types and default sizes for the angle table controller
package angle_table_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 18;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_WR, GNT_RD} gnt_e;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a registered last-grant flag
module rr_arb2 #(
  parameter logic LAST_B_RST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);
  logic last_b_q;
  assign gnt_a_o = req_a_i && (!req_b_i || last_b_q);
  assign gnt_b_o = req_b_i && (!req_a_i || !last_b_q);
  // flip the fairness flag only when both contend
  always_ff @(posedge clk)
    if (!rst_n) last_b_q <= LAST_B_RST;
    else if (req_a_i && req_b_i) last_b_q <= gnt_b_o;
endmodule

// File: rtl/angle_table_ctrl.sv
// angle_table_ctrl: arbitrates the angle RAM between host writes and a streaming table sweep
module angle_table_ctrl
  import angle_table_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             wr_req,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_index,
  output logic             out_last,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_e           state_q, state_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [AW-1:0]    out_index_q, out_index_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;
  logic             rd_want, gnt_wr, gnt_rd, wr_bad;
  gnt_e             gnt;
  assign rd_want = rst_n && state_q == SWEEP && (!out_valid_q || out_ready);
  assign wr_bad  = wr_addr > LAST;
  rr_arb2 #(.LAST_B_RST(1'b1)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a_i (rst_n && wr_req),
    .req_b_i (rd_want),
    .gnt_a_o (gnt_wr),
    .gnt_b_o (gnt_rd)
  );
  assign gnt       = gnt_wr ? GNT_WR : gnt_rd ? GNT_RD : GNT_NONE;
  assign ram_we    = gnt == GNT_WR && !wr_bad;
  assign ram_addr  = gnt == GNT_WR ? wr_addr : rd_ptr_q;
  assign ram_wdata = gnt == GNT_WR ? wr_data : '0;
  assign wr_ack    = gnt == GNT_WR;
  assign wr_err    = wr_ack && wr_bad;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  // sweep sequencing and output register next state
  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: if (start) begin
        state_d  = SWEEP;
        rd_ptr_d = '0;
      end
      SWEEP: if (gnt == GNT_RD) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = rd_ptr_q == LAST ? DRAIN : SWEEP;
      end
      DRAIN: if (out_valid_q && out_ready && out_last_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (gnt == GNT_RD) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_rdata;
      out_index_d = rd_ptr_q;
      out_last_d  = rd_ptr_q == LAST;
    end
  end
  // state and output registers
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
    end
endmodule

// File: tb/tb_angle_table_ctrl.sv
// tb_angle_table_ctrl: directed checks of the angle table controller against a behavioural RAM
module tb_angle_table_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        busy, done;
  logic        wr_req = 0;
  logic [4:0]  wr_addr = 0;
  logic [31:0] wr_data = 0;
  logic        wr_ack, wr_err;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        ram_we;
  logic [4:0]  ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [18];
  logic        preload = 1;
  int          cyc = 0;
  int          n_tests = 0, n_fail = 0, n_done = 0, done_cyc = 0;
  int          b_idx[$], b_cyc[$];
  logic [31:0] b_dat[$];
  bit          b_last[$];
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;
  bit   [3:0]  pat = 4'b1001;
  angle_table_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );
  always #5 clk = ~clk;
  assign ram_rdata = (ram_addr < 5'd18) ? mem[ram_addr] : 32'h0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) for (int k = 0; k < 18; k++) mem[k] <= 32'h100 + k;
    else if (ram_we && ram_addr < 5'd18) mem[ram_addr] <= ram_wdata;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && prev_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, prev_data);
      check("hold_index", out_index, prev_idx);
    end
    prev_stall = rst_n && out_valid && !out_ready;
    prev_data  = out_data;
    prev_idx   = out_index;
    if (rst_n && out_valid && out_ready) begin
      b_idx.push_back(out_index);
      b_dat.push_back(out_data);
      b_last.push_back(out_last);
      b_cyc.push_back(cyc);
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_sweep(input bit stall, input bit wr_on, input bit restart);
    b_idx.delete(); b_dat.delete(); b_last.delete(); b_cyc.delete();
    n_done = 0;
    out_ready = 1;
    start = 1;
    step();
    start = 0;
    for (int t = 0; t < 150 && n_done == 0; t++) begin
      out_ready = stall ? pat[t%4] : 1'b1;
      start = restart && t == 5;
      wr_req = wr_on;
      wr_addr = 5'd5;
      wr_data = 32'hDEADBEEF;
      step();
    end
    start = 0;
    wr_req = 0;
    out_ready = 1;
    check("sweep_timeout", n_done != 0, 1);
    step();
    step();
    check("busy_after", busy, 0);
  endtask
  task automatic verify(input string nm, input bit wr5, input int gap);
    check({nm, "_beats"}, b_idx.size(), 18);
    check({nm, "_done_cnt"}, n_done, 1);
    if (b_idx.size() == 18) begin
      for (int i = 0; i < 18; i++) begin
        check({nm, "_index"}, b_idx[i], i);
        check({nm, "_data"}, b_dat[i], (wr5 && i == 5) ? 32'hDEADBEEF : 32'h100 + i);
        check({nm, "_last"}, b_last[i], i == 17);
        if (gap > 0 && i > 0) check({nm, "_gap"}, b_cyc[i] - b_cyc[i-1], gap);
      end
      if (gap > 0) check({nm, "_done_cyc"}, done_cyc, b_cyc[17] + 1);
    end
  endtask
  initial begin
    int bad;
    bit found;
    rst_n = 0;
    wr_req = 1;
    wr_addr = 5'd2;
    wr_data = 32'h55;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_last", out_last, 0);
    check("rst_we", ram_we, 0);
    check("rst_ack", wr_ack, 0);
    check("rst_err", wr_err, 0);
    wr_req = 0;
    rst_n = 1;
    preload = 0;
    step();
    check("idle_addr", ram_addr, 0);
    check("idle_wdata", ram_wdata, 0);
    check("idle_we", ram_we, 0);
    do_sweep(0, 0, 0);
    verify("basic", 0, 1);
    do_sweep(1, 0, 0);
    verify("stall", 0, 0);
    do_sweep(0, 1, 0);
    verify("wrmix", 1, 2);
    preload = 1;
    step();
    preload = 0;
    wr_req = 1;
    wr_addr = 5'd20;
    wr_data = 32'h12345678;
    #1;
    check("bad_ack", wr_ack, 1);
    check("bad_err", wr_err, 1);
    check("bad_we", ram_we, 0);
    step();
    wr_req = 0;
    #1;
    check("bad_ack_pulse", wr_ack, 0);
    bad = 0;
    for (int k = 0; k < 18; k++) if (mem[k] !== 32'h100 + k) bad++;
    check("bad_mem_intact", bad, 0);
    wr_req = 1;
    wr_addr = 5'd3;
    wr_data = 32'hCAFE0003;
    #1;
    check("good_we", ram_we, 1);
    check("good_addr", ram_addr, 3);
    check("good_wdata", ram_wdata, 32'hCAFE0003);
    check("good_err", wr_err, 0);
    step();
    wr_req = 0;
    check("good_mem", mem[3], 32'hCAFE0003);
    preload = 1;
    step();
    preload = 0;
    n_done = 0;
    start = 1;
    step();
    start = 0;
    found = 0;
    for (int t = 0; t < 40 && !found; t++) begin
      if (out_valid && out_index == 5'd9) found = 1;
      else step();
    end
    check("rst_mid_found", found, 1);
    rst_n = 0;
    step();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    rst_n = 1;
    for (int t = 0; t < 4; t++) step();
    check("rst_mid_no_done", n_done, 0);
    do_sweep(0, 0, 0);
    verify("after_rst", 0, 1);
    do_sweep(0, 0, 1);
    verify("restart", 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/angle_table_ctrl.md
Name: angle_table_ctrl

Overview:
- Controller and arbiter for the 18-entry × 32-bit angle coefficient RAM in the FFT postprocess chain.
- Shares the RAM's single address bus between two requesters:
  - a host configuration writer;
  - a sweep reader that streams the whole table, index 0..DEPTH-1, to the postprocess datapath over a valid/ready interface.
- Drives the RAM's write_enable/address/data_in ports and consumes its combinational data_out.

Parameters:
- WIDTH, 32, coefficient word width.
- DEPTH, 18, number of table entries.
- AW, $clog2(DEPTH), address width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a sweep; ignored unless IDLE.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse after the last beat handshakes.
- wr_req  in  1  level request to write one entry; hold until wr_ack.
- wr_addr  in  AW  target entry.
- wr_data  in  WIDTH  write data.
- wr_ack  out  1  one-cycle pulse; request consumed this cycle.
- wr_err  out  1  pulses with wr_ack when wr_addr >= DEPTH.
- out_valid  out  1  stream beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  WIDTH  table word.
- out_index  out  AW  entry index of the beat.
- out_last  out  1  high on the beat with index DEPTH-1.
- ram_we  out  1  to RAM write_enable.
- ram_addr  out  AW  to RAM address.
- ram_wdata  out  WIDTH  to RAM data_in.
- ram_rdata  in  WIDTH  from RAM data_out (combinational read).

Behaviour:
- Reset (rst_n=0 at posedge) sets:
  - state=IDLE, rd_ptr=0, rr_last=READ (write has priority on the next contention);
  - out_valid=0, out_data=0, out_index=0, out_last=0, done=0.
- Combinational outputs are 0 while rst_n is low: ram_we, wr_ack, wr_err.
- RAM contents are untouched by reset.
- Mid-sweep reset aborts the sweep: no done pulse, partial stream discarded.
- FSM states:
  - IDLE: on start, go to SWEEP, rd_ptr=0.
  - SWEEP: issues reads.
    - When the read of index DEPTH-1 is issued, go to DRAIN.
  - DRAIN: when out_valid && out_ready && out_last, done=1 for one cycle, then return to IDLE.
- Read slot:
  - A read is wanted when state==SWEEP and the output register is free (out_valid==0 or out_ready==1).
  - A granted read captures on the posedge: out_data<=ram_rdata, out_index<=rd_ptr, out_last<=(rd_ptr==DEPTH-1), out_valid<=1, rd_ptr++.
  - Read latency: grant to out_valid is 1 cycle.
- Output register:
  - Clears out_valid when out_ready is high and no new read is granted.
  - Holds data stable while out_valid && !out_ready.
- Arbitration, combinational, one grant per cycle:
  - Only one requester active: that requester wins.
  - Both requesting: the requester opposite rr_last wins; rr_last updates on every contended grant.
  - Full rate: a stalled-free sweep with a constant wr_req interleaves W,R,W,R.
- Write grant:
  - ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1 in the same cycle; the RAM commits at the posedge.
  - If wr_addr >= DEPTH: ram_we=0, wr_ack=1, wr_err=1; the RAM is unchanged.
- Idle bus: ram_addr=rd_ptr, ram_we=0, ram_wdata=0.
- Write/sweep hazard: a write to an index already streamed is not re-streamed. A write to a not-yet-read index is visible in this sweep.
- start while busy is ignored, with no queuing.
- start and wr_req in the same cycle in IDLE: the write is granted; the sweep's first read comes next cycle at the earliest.

Decomposition:
- Package angle_table_pkg holds:
  - state enum typedef {IDLE, SWEEP, DRAIN};
  - grant typedef {GNT_NONE, GNT_WR, GNT_RD};
  - default WIDTH/DEPTH constants.
- One sub-module, rr_arb2: 2-requester round-robin arbiter with a registered last-grant flag. It is reusable for other shared postprocess RAMs.
- The RAM itself is instantiated alongside this controller at the next level up, not inside it.

Test Plan:
- Reset then start with out_ready=1, table preloaded k→0x100+k -> 18 beats on consecutive cycles, index 0..17, data 0x100..0x111, out_last only on index 17, done one cycle after beat 17, busy low afterward.
- out_ready toggled 1,0,0,1,… during a sweep -> out_data and out_index held while stalled; no beat lost or duplicated; rd_ptr advances only on free-slot cycles.
- wr_req held constantly with wr_addr=5, wr_data=0xDEADBEEF during a sweep -> grants alternate W/R. Index 5 streams 0xDEADBEEF if the write precedes its read, else the old value; each wr_ack is one cycle.
- Write with wr_addr=20 -> wr_ack=1 and wr_err=1 for one cycle, ram_we=0, RAM contents unchanged.
- rst_n low at beat 9 of a sweep -> next cycle out_valid=0, busy=0, no done; a new start then streams from index 0.
- start pulsed during SWEEP -> ignored; exactly 18 beats and a single done pulse.
